// File: rtl/mvm_pkg.sv
// Shared types and arithmetic helpers for the sequential matrix-vector engine.
package mvm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int SATW = 64;

    // Wide enough to hold bias plus N full-scale products without overflow.
    function automatic int acc_width(input int dw, input int ow, input int n);
        int prod_w;
        prod_w = 2 * dw + $clog2(n);
        return ((ow > prod_w) ? ow : prod_w) + 1;
    endfunction

    function automatic logic signed [SATW-1:0] sat_clip(
        input  logic signed [SATW-1:0] value,
        input  int                     ow,
        output logic                   clipped
    );
        logic signed [SATW-1:0] hi;
        logic signed [SATW-1:0] lo;
        hi      = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        clipped = 1'b0;
        if (value > hi) begin
            clipped = 1'b1;
            return hi;
        end
        if (value < lo) begin
            clipped = 1'b1;
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/mvm_row_lane.sv
// One output row: a signed multiplier feeding an exact accumulator.
// acc presents the post-edge value so the top can register results on the final step.
module mvm_row_lane
    import mvm_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int OW = 16,
    parameter int IW = acc_width(DW, OW, N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic signed [DW-1:0] w,
    input  logic signed [DW-1:0] x,
    input  logic signed [OW-1:0] bias,
    output logic signed [IW-1:0] acc
);

    logic signed [IW-1:0]   acc_q;
    logic signed [IW-1:0]   acc_d;
    logic signed [2*DW-1:0] prod;

    always_comb begin
        prod  = w * x;
        acc_d = acc_q;
        if (load) begin
            acc_d = IW'(bias);
        end else if (step) begin
            acc_d = acc_q + IW'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_d;

endmodule

// File: rtl/mvm_seq_engine.sv
// Y = sat(W*x + B) with optional ReLU, one column per cycle over M parallel row lanes.
// Result valid N cycles after accept; output held under backpressure, input stalls meanwhile.
module mvm_seq_engine
    import mvm_pkg::*;
#(
    parameter int N  = 4,
    parameter int M  = 4,
    parameter int DW = 8,
    parameter int OW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              relu_en,
    input  logic [N*DW-1:0]   x_flat,
    input  logic [M*N*DW-1:0] w_flat,
    input  logic [M*OW-1:0]   b_flat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M*OW-1:0]   y_flat,
    output logic [M-1:0]      sat_flags
);

    localparam int            IW       = acc_width(DW, OW, N);
    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic                relu_q, relu_d;
    logic [N*DW-1:0]     x_q, x_d;
    logic [M*N*DW-1:0]   w_q, w_d;
    logic [M*OW-1:0]     y_q, y_d;
    logic [M-1:0]        sat_q, sat_d;
    logic                load, step, accept;

    logic signed [IW-1:0]   acc [M];
    logic signed [DW-1:0]   x_sel;
    logic signed [DW-1:0]   w_sel [M];
    logic [M*OW-1:0]        fmt_y;
    logic [M-1:0]           fmt_sat;
    logic signed [SATW-1:0] fmt_r, fmt_c;
    logic                   fmt_f;

    assign x_sel = x_q[col_q*DW +: DW];

    // Bias goes straight from the input port: it is only consumed on the accept edge.
    for (genvar i = 0; i < M; i++) begin : g_lane
        assign w_sel[i] = w_q[(i*N + col_q)*DW +: DW];

        mvm_row_lane #(
            .N  (N),
            .DW (DW),
            .OW (OW),
            .IW (IW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load),
            .step  (step),
            .w     (w_sel[i]),
            .x     (x_sel),
            .bias  (b_flat[i*OW +: OW]),
            .acc   (acc[i])
        );
    end

    // ReLU first, so a ReLU'd row can only clip at the positive bound.
    always_comb begin
        fmt_y   = '0;
        fmt_sat = '0;
        fmt_r   = '0;
        fmt_c   = '0;
        fmt_f   = 1'b0;
        for (int i = 0; i < M; i++) begin
            fmt_r = SATW'(acc[i]);
            if (relu_q && fmt_r < 0) begin
                fmt_r = '0;
            end
            fmt_c              = sat_clip(fmt_r, OW, fmt_f);
            fmt_y[i*OW +: OW]  = fmt_c[OW-1:0];
            fmt_sat[i]         = fmt_f;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        relu_d   = relu_q;
        x_d      = x_q;
        w_d      = w_q;
        y_d      = y_q;
        sat_d    = sat_q;
        in_ready = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            RUN: begin
                step  = 1'b1;
                col_d = col_q + 1'b1;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    y_d     = fmt_y;
                    sat_d   = fmt_sat;
                    state_d = DONE;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        accept = in_valid && in_ready;
        if (accept) begin
            load    = 1'b1;
            x_d     = x_flat;
            w_d     = w_flat;
            relu_d  = relu_en;
            col_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            relu_q  <= 1'b0;
            x_q     <= '0;
            w_q     <= '0;
            y_q     <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            relu_q  <= relu_d;
            x_q     <= x_d;
            w_q     <= w_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign y_flat    = y_q;
    assign sat_flags = sat_q;

endmodule

// File: tb/tb_mvm_seq_engine.sv
// Bench for mvm_seq_engine: two configurations (N=2,M=2 and N=4,M=3) against an arithmetic model.
module tb_mvm_seq_engine;

    typedef struct {
        longint     y [3];
        logic [2:0] sat;
    } exp_t;

    // Hand-computed results for the directed jobs, per configuration.
    localparam longint LIT [2][5][3] = '{
        '{'{21, 19, 0}, '{0, 19, 0}, '{-89, 19, 0}, '{32767, 32258, 0}, '{-32768, -32512, 0}},
        '{'{60, 102, 201}, '{0, 102, 0}, '{-50, 102, -106}, '{32767, 32767, 32767},
          '{-32768, -32768, -32768}}
    };
    localparam int LSAT [2][5] = '{'{0, 0, 0, 1, 1}, '{0, 0, 0, 7, 7}};
    localparam int BTAB [5][3] = '{'{10, -20, 7}, '{-100, -20, -300}, '{-100, -20, -300},
                                   '{1000, 0, 0}, '{-1000, 0, 0}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rbyte(input bit ext);
        if (ext) return ($urandom_range(0, 1) != 0) ? 8'h7f : 8'h80;
        return 8'($urandom);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int TN = (g == 0) ? 2 : 4;
        localparam int TM = (g == 0) ? 2 : 3;

        logic                 rst_n, in_valid, in_ready, relu_en, out_valid, out_ready;
        logic [TN*8-1:0]      x_flat;
        logic [TM*TN*8-1:0]   w_flat;
        logic [TM*16-1:0]     b_flat, y_flat, prev_y;
        logic [TM-1:0]        sat_flags, prev_sat;
        int                   cyc = 0;
        bit                   busy = 0;
        bit                   prev_hold = 0;
        bit                   rnd = 0;
        bit                   done = 0;
        exp_t                 exp_q [$];
        int                   acc_cyc [$];
        int                   hs_cyc [$];

        mvm_seq_engine #(.N(TN), .M(TM), .DW(8), .OW(16)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .relu_en   (relu_en),
            .x_flat    (x_flat),
            .w_flat    (w_flat),
            .b_flat    (b_flat),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .y_flat    (y_flat),
            .sat_flags (sat_flags)
        );

        function automatic exp_t model(input logic [TN*8-1:0] xf, input logic [TM*TN*8-1:0] wf,
                                       input logic [TM*16-1:0] bf, input logic relu);
            exp_t   e;
            longint a;
            for (int i = 0; i < 3; i++) e.y[i] = 0;
            e.sat = '0;
            for (int i = 0; i < TM; i++) begin
                a = longint'($signed(bf[i*16 +: 16]));
                for (int j = 0; j < TN; j++)
                    a += longint'($signed(wf[(i*TN + j)*8 +: 8])) * longint'($signed(xf[j*8 +: 8]));
                if (relu && a < 0) a = 0;
                if (a > 32767) begin
                    a = 32767;
                    e.sat[i] = 1'b1;
                end else if (a < -32768) begin
                    a = -32768;
                    e.sat[i] = 1'b1;
                end
                e.y[i] = a;
            end
            return e;
        endfunction

        always @(posedge clk) cyc++;

        always @(negedge clk) begin : cmp
            exp_t e;
            if (!rst_n) begin
                chk($sformatf("c%0d rst out_valid", g), longint'(out_valid), 0);
                chk($sformatf("c%0d rst in_ready", g), longint'(in_ready), 1);
                chk($sformatf("c%0d rst y_flat", g), longint'(y_flat), 0);
                chk($sformatf("c%0d rst sat_flags", g), longint'(sat_flags), 0);
                exp_q.delete();
                acc_cyc.delete();
                busy      = 0;
                prev_hold = 0;
            end else begin
                chk($sformatf("c%0d in_ready", g), longint'(in_ready),
                    longint'(!busy || (out_valid && out_ready)));
                if (prev_hold) begin
                    chk($sformatf("c%0d valid held", g), longint'(out_valid), 1);
                    chk($sformatf("c%0d y held", g), longint'(y_flat), longint'(prev_y));
                    chk($sformatf("c%0d sat held", g), longint'(sat_flags), longint'(prev_sat));
                end else if (out_valid) begin
                    if (acc_cyc.size() == 0)
                        chk($sformatf("c%0d valid without job", g), acc_cyc.size(), 1);
                    else
                        chk($sformatf("c%0d latency", g), cyc - acc_cyc.pop_front(), TN);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("c%0d result without job", g), exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < TM; i++)
                            chk($sformatf("c%0d y%0d", g, i),
                                longint'($signed(y_flat[i*16 +: 16])), e.y[i]);
                        chk($sformatf("c%0d sat_flags", g), longint'(sat_flags),
                            longint'(e.sat[TM-1:0]));
                    end
                    hs_cyc.push_back(cyc);
                    busy = 0;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(x_flat, w_flat, b_flat, relu_en));
                    acc_cyc.push_back(cyc + 1);
                    busy = 1;
                end
                prev_hold = out_valid && !out_ready;
                prev_y    = y_flat;
                prev_sat  = sat_flags;
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        endtask

        task automatic set_dir(input int k);
            for (int j = 0; j < TN; j++)
                x_flat[j*8 +: 8] = (k >= 3) ? 8'h7f : 8'(j + 3);
            for (int i = 0; i < TM; i++)
                for (int j = 0; j < TN; j++)
                    w_flat[(i*TN + j)*8 +: 8] = (k == 3) ? 8'h7f : (k == 4) ? 8'h80 : 8'(4*i + j + 1);
            for (int i = 0; i < TM; i++)
                b_flat[i*16 +: 16] = 16'(BTAB[k][i]);
            relu_en = (k == 1);
        endtask

        task automatic set_rand();
            bit ext;
            ext = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < TN; j++) x_flat[j*8 +: 8] = rbyte(ext);
            for (int k = 0; k < TM*TN; k++) w_flat[k*8 +: 8] = rbyte(ext);
            for (int i = 0; i < TM; i++) b_flat[i*16 +: 16] = 16'($urandom);
            relu_en = 1'($urandom_range(0, 1));
        endtask

        // Called just after a rising edge; returns just after the accepting edge.
        task automatic send();
            int t;
            t = 0;
            in_valid = 1'b1;
            #1;
            while (!in_ready && t < 300) begin
                tick();
                #1;
                t++;
            end
            if (!in_ready) chk($sformatf("c%0d accept timeout", g), t, 0);
            else @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        task automatic drain();
            int t;
            t = 0;
            while ((busy || exp_q.size() != 0) && t < 500) begin
                tick();
                t++;
            end
            chk($sformatf("c%0d drain", g), longint'(t < 500), 1);
        endtask

        initial begin : stim
            exp_t pe;
            int   t;
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            relu_en   = 1'b0;
            out_ready = 1'b1;
            x_flat    = '0;
            w_flat    = '0;
            b_flat    = '0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;

            for (int k = 0; k < 5; k++) begin
                set_dir(k);
                pe = model(x_flat, w_flat, b_flat, relu_en);
                for (int i = 0; i < TM; i++)
                    chk($sformatf("c%0d lit job%0d y%0d", g, k, i), pe.y[i], LIT[g][k][i]);
                chk($sformatf("c%0d lit job%0d sat", g, k), longint'(pe.sat), LSAT[g][k]);
                send();
                drain();
            end

            out_ready = 1'b0;
            set_dir(0);
            send();
            t = 0;
            while (!out_valid && t < 50) begin
                tick();
                t++;
            end
            chk($sformatf("c%0d bp valid", g), longint'(out_valid), 1);
            repeat (5) begin
                tick();
                set_rand();
                in_valid = 1'($urandom_range(0, 1));
            end
            tick();
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
            chk($sformatf("c%0d bp handoff", g), longint'(out_valid), 0);
            drain();

            set_dir(0);
            send();
            set_dir(3);
            send();
            drain();
            chk($sformatf("c%0d b2b spacing", g), hs_cyc[$] - hs_cyc[$-1], TN + 1);

            set_dir(2);
            send();
            #2 rst_n = 1'b0;
            #1;
            chk($sformatf("c%0d async rst out_valid", g), longint'(out_valid), 0);
            chk($sformatf("c%0d async rst y_flat", g), longint'(y_flat), 0);
            tick();
            tick();
            rst_n = 1'b1;
            set_dir(0);
            send();
            drain();

            rnd = 1;
            for (int n = 0; n < 30; n++) begin
                set_rand();
                send();
                repeat ($urandom_range(0, 2)) tick();
            end
            rnd       = 0;
            out_ready = 1'b1;
            drain();
            done = 1;
        end
    end

    initial begin : fin
        int t;
        t = 0;
        while (!(cfg[0].done && cfg[1].done) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("bench completion", longint'(cfg[0].done && cfg[1].done), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
